em_counter_n: RTL
=================

EM_COUNTER_N -- requirements
Module: em_counter_n

Interface
REQ-001 Parameter WIDTH, default 4: counter register width in bits; legal range 1..32.
REQ-002 Parameter MODULUS, default 16: count sequence length; legal range 2..2**WIDTH; MODULUS=10 with WIDTH=4 gives a decade counter.
REQ-003 Parameter UPDOWN, default 1: 1 enables the up/down input; 0 ties direction internally to up and ignores the up input.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 clr  input  1  synchronous reset, active-high.
REQ-006 nload  input  1  active-low synchronous parallel load.
REQ-007 ent  input  1  count-enable T; also gates rco.
REQ-008 enp  input  1  count-enable P.
REQ-009 up  input  1  direction: 1 counts up, 0 counts down.
REQ-010 parallel_in  input  WIDTH  load value.
REQ-011 count  output  WIDTH  registered counter value.
REQ-012 rco  output  1  combinational ripple-carry/borrow (terminal count) output.
REQ-013 wrapped  output  1  registered sticky flag, set on any count wrap.

Function
REQ-014 Edge priority, highest first: clr, then nload=0, then count (ent=1 and enp=1), else hold.
REQ-015 clr=1 at an edge: count <= 0, wrapped <= 0, regardless of all other inputs.
REQ-016 nload=0 (clr=0): count <= parallel_in unmodified, including values >= MODULUS; wrapped unchanged; ent/enp ignored.
REQ-017 Up count: count < MODULUS-1 -> count+1; count >= MODULUS-1 -> 0 and wrapped <= 1.
REQ-018 Down count: 0 < count <= MODULUS-1 -> count-1; count = 0 -> MODULUS-1 and wrapped <= 1; count > MODULUS-1 -> MODULUS-1, wrapped unchanged.
REQ-019 Out-of-range count values, reachable only by load, recover within one counting edge per REQ-017 and REQ-018.
REQ-020 Hold: ent=0 or enp=0 with nload=1 and clr=0 -> count and wrapped unchanged.
REQ-021 rco = ent AND ((up AND count >= MODULUS-1) OR (NOT up AND count = 0)), using the effective direction; it is independent of enp, nload and clr.
REQ-022 rco settles in the same cycle as count or up changes, with no register delay, so that chained instances (rco -> next ent, common enp) cascade synchronously.
REQ-023 Arithmetic is performed in WIDTH bits; the result never exceeds MODULUS-1 except immediately after a load.
REQ-024 wrapped clears only on clr; a load does not clear it.
REQ-025 A direction change takes effect at the next counting edge; no state is retained about the previous direction.
REQ-026 With MODULUS = 2**WIDTH, behaviour equals a plain binary up/down counter wrapping at all-ones and all-zeros.

Reset
REQ-027 After any edge with clr=1: count=0, wrapped=0, and rco = ent AND NOT up (with UPDOWN=0, rco=0).
REQ-028 Reset is synchronous: asserting clr between edges does not change count until the next rising edge.
REQ-029 Reset applied mid-count, mid-load or in the same cycle as nload=0 wins; the load is discarded.
REQ-030 Before the first clr edge, outputs are unspecified; the bench shall apply clr for at least 1 cycle at start.

Verification
REQ-031 WIDTH=4, MODULUS=10, up=1, ent=enp=1, from clr: 10 edges -> count 1..9 then 0; rco=1 only while count=9; wrapped=1 after the 10th edge.
REQ-032 MODULUS=10, load 4'hC, then 1 up edge -> count=0 and wrapped=1; load 4'hC then 1 down edge -> count=9 and wrapped unchanged.
REQ-033 MODULUS=10, up=0, count=0, ent=1 -> rco=1; 1 edge -> count=9 and wrapped=1; ent=0 -> rco=0 and count holds.
REQ-034 clr=1 and nload=0 with parallel_in=5 in the same cycle -> count=0 and wrapped=0; next edge with clr=0, nload=0 -> count=5.
REQ-035 Two WIDTH=4, MODULUS=16 instances cascaded via rco->ent, counting up from 0 -> combined value increments by 1 per edge through 255 -> 0 with no skipped or double counts.
REQ-036 enp=0 with ent=1 and count at terminal value -> count holds and rco stays 1; UPDOWN=0 with up=0 -> still counts upward.

Source files
------------

// File: rtl/em_counter_n.sv
// Modulo-N synchronous up/down counter with parallel load, cascadable
// ripple-carry output and a sticky wrap flag.
module em_counter_n #(
    parameter int               WIDTH   = 4,
    parameter longint unsigned  MODULUS = 16,
    parameter int               UPDOWN  = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             nload,
    input  logic             ent,
    input  logic             enp,
    input  logic             up,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] count,
    output logic             rco,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] TERM_C = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrapped_q;
    logic             wrapped_d;
    logic             dir_up_s;
    logic             at_term_s;

    // With UPDOWN=0 the direction is hard-wired to up and the up pin is unused.
    if (UPDOWN != 0) begin : g_dir_pin
        assign dir_up_s = up;
    end else begin : g_dir_fixed
        assign dir_up_s = 1'b1;
    end

    // Terminal count for the effective direction; also used for out-of-range recovery.
    always_comb begin
        at_term_s = 1'b0;
        if (dir_up_s) begin
            at_term_s = (count_q >= TERM_C);
        end else begin
            at_term_s = (count_q == ZERO_C);
        end
    end

    // Next-state for load / count / hold; clr is handled in the register block.
    always_comb begin
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (!nload) begin
            count_d = parallel_in;
        end else if (ent && enp) begin
            if (dir_up_s) begin
                if (at_term_s) begin
                    count_d   = ZERO_C;
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (at_term_s) begin
                    count_d   = TERM_C;
                    wrapped_d = 1'b1;
                end else if (count_q > TERM_C) begin
                    // Loaded out-of-range value snaps to the top without flagging a wrap.
                    count_d = TERM_C;
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end else begin
            count_d   = count_q;
            wrapped_d = wrapped_q;
        end
    end

    // State registers with synchronous clear taking priority over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q   <= ZERO_C;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;
    // rco stays combinational so chained stages see the carry in the same cycle.
    assign rco     = ent & at_term_s;

endmodule
